// File: rtl/manchester_encoder_pkg.sv
// manchester_pkg: shared constants, encoder state encoding and the
// Manchester symbol helper used by the encoder and its testbench.
package manchester_pkg;

  // Frame framing produced upstream by the preamble inserter.
  localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
  localparam logic [7:0] START_WORD       = 8'hD5;
  localparam int         PREAMBLE_TIMES   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EOF   = 2'd2
  } enc_state_e;

  // Line level for one half of a bit symbol.
  // polarity=1 (IEEE): first half ~b, second half b. polarity=0 inverts both.
  function automatic logic man_sym(input logic b, input logic half, input logic polarity);
    logic lvl;
    lvl = half ? b : ~b;
    return polarity ? lvl : ~lvl;
  endfunction

endpackage

// File: rtl/manchester_encoder_if.sv
// manchester_axis_if: AXI-stream style byte input to the encoder.
//   tdata/tvalid/tlast : master -> slave
//   tready             : slave  -> master
interface manchester_axis_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/manchester_encoder_half_bit_timer.sv
// manchester_half_bit_timer: half-bit / bit position counters for the encoder.
//   aclk, aresetn : clock, synchronous active-low reset
//   clr_i         : synchronous clear of all counters (priority over en_i)
//   en_i          : count enable (encoder in SHIFT)
//   half_tick_o   : last cycle of the current half-bit
//   phase_o       : 0 = first half of the bit, 1 = second half
//   last_bit_o    : current bit is the last bit of the beat
module manchester_half_bit_timer #(
  parameter int HALF_BIT_CYCLES = 4,
  parameter int DATA_WIDTH      = 8
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr_i,
  input  logic en_i,
  output logic half_tick_o,
  output logic phase_o,
  output logic last_bit_o
);
  localparam int HCW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int BCW = $clog2(DATA_WIDTH);

  logic [HCW-1:0] half_cnt_q, half_cnt_d;
  logic           phase_q, phase_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;

  assign half_tick_o = en_i && (half_cnt_q == HCW'(HALF_BIT_CYCLES - 1));
  assign phase_o     = phase_q;
  assign last_bit_o  = (bit_cnt_q == BCW'(DATA_WIDTH - 1));

  // bit_cnt wraps to 0 after the last bit so a gapless reload needs no clear.
  always_comb begin
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr_i) begin
      half_cnt_d = '0;
      phase_d    = 1'b0;
      bit_cnt_d  = '0;
    end else if (en_i) begin
      if (half_tick_o) begin
        half_cnt_d = '0;
        phase_d    = ~phase_q;
        if (phase_q)
          bit_cnt_d = last_bit_o ? '0 : bit_cnt_q + 1'b1;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/manchester_encoder.sv
// manchester_encoder: serialises framed bytes into a Manchester line signal.
//   aclk, aresetn : clock, synchronous active-low reset
//   s_axis        : byte input (tdata/tvalid/tlast in, tready out = !hold_valid)
//   tx_out        : registered Manchester line
//   tx_en         : registered, high while a frame's symbols are driven
//   busy          : FSM not idle or a byte is held
//   underrun      : 1-cycle pulse, hold empty at a byte boundary inside a frame
module manchester_encoder
  import manchester_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int HALF_BIT_CYCLES = 4,
  parameter int LSB_FIRST       = 1,
  parameter int IEEE_POLARITY   = 1,
  parameter int IDLE_LEVEL      = 0,
  parameter int EOF_HALF_BITS   = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  manchester_axis_if.slave  s_axis,
  output logic              tx_out,
  output logic              tx_en,
  output logic              busy,
  output logic              underrun
);
  localparam int   EOF_CYCLES = EOF_HALF_BITS * HALF_BIT_CYCLES;
  localparam int   ECW        = (EOF_CYCLES > 1) ? $clog2(EOF_CYCLES) : 1;
  localparam logic POL        = (IEEE_POLARITY != 0);
  localparam logic IDLE_LVL   = (IDLE_LEVEL != 0);

  enc_state_e            state_q, state_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  last_r_q, last_r_d;
  logic [ECW-1:0]        eof_cnt_q, eof_cnt_d;
  logic                  tx_out_q, tx_out_d;
  logic                  tx_en_q, tx_en_d;
  logic                  underrun_q, underrun_d;
  logic                  load;

  logic half_tick, phase, last_bit;
  logic byte_end, eof_done;
  logic cur_bit, nxt_bit, hold_first;

  manchester_half_bit_timer #(
    .HALF_BIT_CYCLES (HALF_BIT_CYCLES),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_timer (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .clr_i       (state_q != SHIFT),
    .en_i        (state_q == SHIFT),
    .half_tick_o (half_tick),
    .phase_o     (phase),
    .last_bit_o  (last_bit)
  );

  assign byte_end   = half_tick && phase && last_bit;
  assign eof_done   = (eof_cnt_q == ECW'(EOF_CYCLES - 1));
  // The shifter always presents the bit on air at one end; next bit beside it.
  assign cur_bit    = (LSB_FIRST != 0) ? shift_q[0]     : shift_q[DATA_WIDTH-1];
  assign nxt_bit    = (LSB_FIRST != 0) ? shift_q[1]     : shift_q[DATA_WIDTH-2];
  assign hold_first = (LSB_FIRST != 0) ? hold_data_q[0] : hold_data_q[DATA_WIDTH-1];

  assign s_axis.tready = !hold_valid_q;
  assign busy          = (state_q != IDLE) || hold_valid_q;
  assign tx_out        = tx_out_q;
  assign tx_en         = tx_en_q;
  assign underrun      = underrun_q;

  // State register plus the datapath registers it steers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      shift_q      <= '0;
      last_r_q     <= 1'b0;
      eof_cnt_q    <= '0;
      tx_out_q     <= IDLE_LVL;
      tx_en_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      shift_q      <= shift_d;
      last_r_q     <= last_r_d;
      eof_cnt_q    <= eof_cnt_d;
      tx_out_q     <= tx_out_d;
      tx_en_q      <= tx_en_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next state. A byte already held when EOF expires starts straight away, so
  // the inter-frame gap is exactly EOF_CYCLES rather than EOF_CYCLES+1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_valid_q) state_d = SHIFT;
      SHIFT:   if (byte_end)     state_d = (!last_r_q && hold_valid_q) ? SHIFT : EOF;
      EOF:     if (eof_done)     state_d = hold_valid_q ? SHIFT : IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Outputs and datapath. Next line level is decided at each half_tick so the
  // registered tx_out only moves on half-bit boundaries.
  always_comb begin
    load       = 1'b0;
    shift_d    = shift_q;
    last_r_d   = last_r_q;
    eof_cnt_d  = '0;
    tx_out_d   = tx_out_q;
    tx_en_d    = tx_en_q;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          load     = 1'b1;
          tx_en_d  = 1'b1;
          tx_out_d = man_sym(hold_first, 1'b0, POL);
        end
      end
      SHIFT: begin
        if (half_tick) begin
          if (!phase) begin
            tx_out_d = man_sym(cur_bit, 1'b1, POL);
          end else if (!last_bit) begin
            shift_d  = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
            tx_out_d = man_sym(nxt_bit, 1'b0, POL);
          end else if (last_r_q) begin
            tx_en_d  = 1'b0;
            tx_out_d = IDLE_LVL;
          end else if (hold_valid_q) begin
            load     = 1'b1;
            tx_out_d = man_sym(hold_first, 1'b0, POL);
          end else begin
            // Mid-frame starvation: abort the frame on the line.
            underrun_d = 1'b1;
            tx_en_d    = 1'b0;
            tx_out_d   = IDLE_LVL;
          end
        end
      end
      EOF: begin
        eof_cnt_d = eof_cnt_q + 1'b1;
        if (eof_done) begin
          eof_cnt_d = '0;
          if (hold_valid_q) begin
            load     = 1'b1;
            tx_en_d  = 1'b1;
            tx_out_d = man_sym(hold_first, 1'b0, POL);
          end
        end
      end
      default: ;
    endcase
    if (load) begin
      shift_d  = hold_data_q;
      last_r_d = hold_last_q;
    end
  end

  // Hold register: tready=!hold_valid, so a write and a move never coincide.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end else if (s_axis.tvalid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_axis.tdata;
      hold_last_d  = s_axis.tlast;
    end
  end
endmodule

// File: tb/tb_manchester_encoder.sv
// tb_manchester_encoder: table-driven single-byte vectors, hand-written
// multi-cycle sequences and randomized frames against a bit-level line model.
module tb_manchester_encoder;
  localparam int H  = 2;
  localparam int DW = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic tx_out, tx_en, busy, underrun;

  always #5 aclk = ~aclk;

  manchester_axis_if #(.DATA_WIDTH(DW)) axis ();

  manchester_encoder #(
    .DATA_WIDTH(DW), .HALF_BIT_CYCLES(H), .LSB_FIRST(1),
    .IEEE_POLARITY(1), .IDLE_LEVEL(0), .EOF_HALF_BITS(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(axis),
    .tx_out(tx_out), .tx_en(tx_en), .busy(busy), .underrun(underrun)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, idle_bad = 0, ur_cnt = 0;
  logic [7:0] frm_d[$];
  int         acc_cyc[$];
  logic       cap_q[$];
  bit         exp_q[$];
  int         cap_gap, cap_start;

  typedef struct { logic [7:0] data; logic [15:0] pat; } vec_t;
  vec_t tbl[8];

  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) begin
    if (aresetn && !tx_en && tx_out !== 1'b0) idle_bad <= idle_bad + 1;
    if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference line model: each bit b of each byte (LSB first) is sent as the
  // half-bit pair (~b, b); one entry per half-bit.
  task automatic model_frame();
    exp_q.delete();
    foreach (frm_d[i])
      for (int k = 0; k < DW; k++) begin
        exp_q.push_back(!frm_d[i][k]);
        exp_q.push_back(frm_d[i][k]);
      end
  endtask

  task automatic pattern_to_exp(input logic [15:0] pat);
    exp_q.delete();
    for (int k = 15; k >= 0; k--) exp_q.push_back(pat[k]);
  endtask

  // Called at a negedge; feeds frm_d as one frame, tvalid kept high throughout.
  task automatic drive_frame(input bit with_last);
    int guard;
    acc_cyc.delete();
    for (int i = 0; i < frm_d.size(); i++) begin
      axis.tvalid = 1'b1;
      axis.tdata  = frm_d[i];
      axis.tlast  = with_last && (i == frm_d.size() - 1);
      guard = 0;
      while (!axis.tready && guard < 3000) begin
        @(negedge aclk);
        guard++;
      end
      if (guard >= 3000) chk("drive_tready_timeout", guard, 0);
      acc_cyc.push_back(cyc);
      @(negedge aclk);
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  // Called at a negedge; counts idle samples, then records one tx_en burst.
  // Returns at the first negedge where tx_en is low again.
  task automatic capture();
    int guard = 0;
    cap_q.delete();
    cap_gap = 0;
    while (tx_en !== 1'b1 && guard < 4000) begin
      cap_gap++;
      guard++;
      @(negedge aclk);
    end
    if (guard >= 4000) begin
      chk("capture_start_timeout", guard, 0);
      return;
    end
    cap_start = cyc;
    while (tx_en === 1'b1 && cap_q.size() < 8000) begin
      cap_q.push_back(tx_out);
      @(negedge aclk);
    end
  endtask

  task automatic check_burst(input string name);
    bit ok;
    int bad = -1;
    vectors++;
    ok = (cap_q.size() == exp_q.size() * H);
    if (ok)
      foreach (cap_q[i])
        if (bad < 0 && cap_q[i] !== exp_q[i / H]) bad = i;
    if (!ok || bad >= 0) begin
      miscompares++;
      $display("FAIL %s: burst %0d cycles, first bad sample %0d; required %0d cycles matching model",
               name, cap_q.size(), bad, exp_q.size() * H);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 4000) begin
      n++;
      @(negedge aclk);
    end
  endtask

  task automatic single_byte(input string name, input logic [7:0] d, input logic [15:0] pat,
                             input bit chk_lat);
    int n;
    frm_d = '{d};
    fork
      drive_frame(1'b1);
      capture();
    join
    pattern_to_exp(pat);
    check_burst(name);
    if (chk_lat) chk({name, "_latency"}, cap_start - acc_cyc[0], 2);
    wait_idle(n);
    chk({name, "_eof_cycles"}, n, 4);
  endtask

  initial begin
    int n, u0, hi;
    tbl[0] = '{8'hD5, 16'h6665};
    tbl[1] = '{8'h0F, 16'h55AA};
    tbl[2] = '{8'hF0, 16'hAA55};
    tbl[3] = '{8'h00, 16'hAAAA};
    tbl[4] = '{8'hFF, 16'h5555};
    tbl[5] = '{8'hAA, 16'h9999};
    tbl[6] = '{8'h01, 16'h6AAA};
    tbl[7] = '{8'h55, 16'h6666};
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_tx_out", tx_out, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tready", axis.tready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Table of single-byte frames (first entry is the 0xD5 frame)
    foreach (tbl[i]) single_byte($sformatf("tbl%0d", i), tbl[i].data, tbl[i].pat, i == 0);

    // Preamble + start word + payload, gapless across byte boundaries
    frm_d = '{8'hAA, 8'hAA, 8'hD5, 8'h01};
    model_frame();
    fork
      drive_frame(1'b1);
      capture();
    join
    check_burst("frame4");
    chk("frame4_en_cycles", cap_q.size(), 128);
    wait_idle(n);

    // Back-to-back frames: exactly the EOF gap between bursts
    fork
      begin
        frm_d = '{8'h0F}; drive_frame(1'b1);
        frm_d = '{8'hF0}; drive_frame(1'b1);
      end
      begin
        capture(); pattern_to_exp(16'h55AA); check_burst("b2b_first");
        capture(); chk("b2b_gap", cap_gap, 4);
        pattern_to_exp(16'hAA55); check_burst("b2b_second");
      end
    join
    wait_idle(n);

    // Underrun: byte without tlast, then starve
    u0 = ur_cnt;
    frm_d = '{8'h55};
    fork
      drive_frame(1'b0);
      capture();
    join
    pattern_to_exp(16'h6666);
    check_burst("underrun_byte");
    chk("underrun_with_tx_en_low", underrun, 1);
    @(negedge aclk);
    chk("underrun_pulses", ur_cnt - u0, 1);
    frm_d = '{8'hF0};
    fork
      drive_frame(1'b1);
      capture();
    join
    pattern_to_exp(16'hAA55);
    check_burst("after_underrun");
    wait_idle(n);

    // Backpressure: one accept per byte time
    frm_d = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    model_frame();
    fork
      drive_frame(1'b1);
      capture();
    join
    check_burst("bp_frame");
    chk("bp_spacing_a", acc_cyc[2] - acc_cyc[1], 32);
    chk("bp_spacing_b", acc_cyc[3] - acc_cyc[2], 32);
    wait_idle(n);

    // Reset mid-byte
    frm_d = '{8'hD5, 8'h0F};
    fork
      drive_frame(1'b1);
      begin
        n = 0;
        while (tx_en !== 1'b1 && n < 200) begin n++; @(negedge aclk); end
        repeat (7) @(negedge aclk);
      end
    join
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    chk("midrst_tx_out", tx_out, 0);
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_tready", axis.tready, 1);
    chk("midrst_busy", busy, 0);
    hi = 0;
    repeat (40) begin
      @(negedge aclk);
      if (tx_en === 1'b1 || busy === 1'b1) hi++;
    end
    chk("midrst_no_residual", hi, 0);
    single_byte("restart", 8'hD5, 16'h6665, 1'b1);

    // Randomized frames against the model
    for (int f = 0; f < 20; f++) begin
      frm_d.delete();
      for (int b = 0; b < $urandom_range(1, 4); b++) frm_d.push_back(8'($urandom));
      model_frame();
      repeat ($urandom_range(0, 6)) @(negedge aclk);
      fork
        drive_frame(1'b1);
        capture();
      join
      check_burst($sformatf("rand%0d", f));
    end
    wait_idle(n);

    chk("idle_level_when_disabled", idle_bad, 0);
    chk("underrun_total", ur_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
